// File: rtl/legv8_pkg.sv
// Shared LEGv8 core definitions: widths, fetch constants and the IF/ID pipeline register type.
package legv8_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned PC_STEP = 4;

  // CBZ XZR,#0: branches to itself forever, used by programs as a stop marker.
  localparam logic [INSTR_W-1:0] HALT_INSTR = 32'hb400001f;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [XLEN-1:0]    pc;
    logic               valid;
  } ifid_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] word);
    return word == HALT_INSTR;
  endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register: N-bit flop with async active-low reset and load enable.
module pc_reg #(
  parameter int unsigned N = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [N-1:0] next_pc,
  output logic [N-1:0] pc
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc <= '0;
    end else if (load) begin
      pc <= next_pc;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// LEGv8 instruction-fetch stage: PC, ROM addressing, IF/ID register with valid/ready,
// branch redirect and halt-idiom detection.
module fetch_unit
  import legv8_pkg::*;
#(
  parameter int unsigned N       = 64,
  parameter int unsigned IMEM_AW = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               br_taken_i,
  input  logic [N-1:0]       br_target_i,
  input  logic               id_ready_i,
  output logic [IMEM_AW-1:0] imem_addr_o,
  input  logic [INSTR_W-1:0] imem_q_i,
  output logic [INSTR_W-1:0] instr_o,
  output logic [N-1:0]       pc_o,
  output logic               valid_o,
  output logic               halted_o
);

  logic [N-1:0] pc;
  logic [N-1:0] next_pc;
  logic         pc_load;
  logic         accept;
  logic         halt_hit;
  logic         halted;
  ifid_t        ifid;

  assign accept   = (!ifid.valid || id_ready_i) && !halted;
  assign halt_hit = is_halt(imem_q_i);

  // Redirect wins over everything; a fetched halt keeps the PC parked on itself.
  always_comb begin
    pc_load = 1'b0;
    next_pc = pc;
    if (br_taken_i) begin
      pc_load = 1'b1;
      next_pc = br_target_i & ~N'(3);
    end else if (accept && !halt_hit) begin
      pc_load = 1'b1;
      next_pc = pc + N'(PC_STEP);
    end
  end

  pc_reg #(
    .N(N)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .next_pc (next_pc),
    .pc      (pc)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ifid   <= '0;
      halted <= 1'b0;
    end else if (br_taken_i) begin
      ifid.valid <= 1'b0;
      halted     <= 1'b0;
    end else if (accept) begin
      ifid.instr <= imem_q_i;
      ifid.pc    <= XLEN'(pc);
      ifid.valid <= 1'b1;
      halted     <= halt_hit;
    end else if (ifid.valid && id_ready_i) begin
      // Only reachable while halted: decode drains the halt instruction.
      ifid.valid <= 1'b0;
    end
  end

  assign imem_addr_o = pc[IMEM_AW+1:2];
  assign instr_o     = ifid.instr;
  assign pc_o        = ifid.pc[N-1:0];
  assign valid_o     = ifid.valid;
  assign halted_o    = halted;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: ROM model, consumption scoreboard and directed checks.
module tb_fetch_unit;
  import legv8_pkg::*;

  localparam int unsigned N       = 64;
  localparam int unsigned IMEM_AW = 8;

  typedef struct {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  logic               clk = 1'b0;
  logic               reset;
  logic               br_taken_i;
  logic [N-1:0]       br_target_i;
  logic               id_ready_i;
  logic [IMEM_AW-1:0] imem_addr_o;
  logic [31:0]        imem_q_i;
  logic [31:0]        instr_o;
  logic [N-1:0]       pc_o;
  logic               valid_o;
  logic               halted_o;

  logic [31:0] rom [256];
  exp_t        sb [$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  always #5 clk = ~clk;

  always_comb imem_q_i = rom[imem_addr_o];

  fetch_unit #(
    .N       (N),
    .IMEM_AW (IMEM_AW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .br_taken_i  (br_taken_i),
    .br_target_i (br_target_i),
    .id_ready_i  (id_ready_i),
    .imem_addr_o (imem_addr_o),
    .imem_q_i    (imem_q_i),
    .instr_o     (instr_o),
    .pc_o        (pc_o),
    .valid_o     (valid_o),
    .halted_o    (halted_o)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rom_word(input int unsigned k);
    return 32'h1000_0000 + k;
  endfunction

  task automatic push(input logic [63:0] pc);
    exp_t e;
    e.pc    = pc;
    e.instr = rom[pc[9:2]];
    sb.push_back(e);
  endtask

  // Instruction in IF/ID is consumed on an edge where valid_o and id_ready_i are both high.
  task automatic tick();
    exp_t e;
    if (valid_o && id_ready_i) begin
      if (sb.size() == 0) begin
        check_eq("sb_unexpected_consume", {32'h0, instr_o}, 64'hffff_ffff_ffff_ffff);
      end else begin
        e = sb.pop_front();
        check_eq("sb_pc", pc_o, e.pc);
        check_eq("sb_instr", {32'h0, instr_o}, {32'h0, e.instr});
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [63:0] pc, input logic [31:0] instr,
                            input logic valid, input logic halted, input logic [7:0] addr);
    check_eq({tag, "_pc"}, pc_o, pc);
    check_eq({tag, "_instr"}, {32'h0, instr_o}, {32'h0, instr});
    check_eq({tag, "_valid"}, {63'h0, valid_o}, {63'h0, valid});
    check_eq({tag, "_halted"}, {63'h0, halted_o}, {63'h0, halted});
    check_eq({tag, "_addr"}, {56'h0, imem_addr_o}, {56'h0, addr});
  endtask

  // Assert reset away from any edge, check outputs clear immediately, release on a later negedge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    #2;
    reset       = 1'b0;
    br_taken_i  = 1'b0;
    id_ready_i  = 1'b0;
    #1;
    expect_out(tag, 64'h0, 32'h0, 1'b0, 1'b0, 8'd0);
    sb.delete();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic check_queue_empty(input string tag);
    check_eq(tag, 64'(sb.size()), 64'h0);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = rom_word(i);
    reset       = 1'b0;
    br_taken_i  = 1'b0;
    br_target_i = '0;
    id_ready_i  = 1'b0;

    // Reset state held across edges.
    repeat (2) @(posedge clk);
    #1;
    expect_out("rst", 64'h0, 32'h0, 1'b0, 1'b0, 8'd0);
    @(negedge clk);
    reset = 1'b1;

    // 1: free-running fetch.
    id_ready_i = 1'b1;
    push(64'd0); push(64'd4); push(64'd8);
    for (int k = 0; k < 4; k++) begin
      tick();
      expect_out("run", 64'(4 * k), rom_word(k), 1'b1, 1'b0, 8'(k + 1));
    end
    check_queue_empty("run_sb");

    // 2: stall after edge 2.
    do_reset("rst2");
    id_ready_i = 1'b1;
    push(64'd0);
    tick();
    tick();
    expect_out("pre_stall", 64'd4, rom_word(1), 1'b1, 1'b0, 8'd2);
    id_ready_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      expect_out("stall", 64'd4, rom_word(1), 1'b1, 1'b0, 8'd2);
    end
    id_ready_i = 1'b1;
    push(64'd4);
    tick();
    expect_out("unstall", 64'd8, rom_word(2), 1'b1, 1'b0, 8'd3);
    check_queue_empty("stall_sb");

    // 3: redirect during stall, unaligned target.
    id_ready_i  = 1'b0;
    br_taken_i  = 1'b1;
    br_target_i = 64'h43;
    tick();
    expect_out("redir", 64'd8, rom_word(2), 1'b0, 1'b0, 8'd16);
    br_taken_i = 1'b0;
    tick();
    expect_out("redir_fetch", 64'h40, rom_word(16), 1'b1, 1'b0, 8'd17);

    // 6: reset mid-stall with a live instruction, then restart at 0.
    do_reset("rst_mid");
    id_ready_i = 1'b1;
    push(64'd0);
    tick();
    expect_out("restart0", 64'd0, rom_word(0), 1'b1, 1'b0, 8'd1);
    tick();
    expect_out("restart1", 64'd4, rom_word(1), 1'b1, 1'b0, 8'd2);
    check_queue_empty("restart_sb");

    // 4: halt idiom at word 5.
    rom[5] = HALT_INSTR;
    do_reset("rst4");
    id_ready_i = 1'b1;
    for (int k = 0; k < 5; k++) push(64'(4 * k));
    for (int k = 0; k < 6; k++) tick();
    expect_out("halt", 64'd20, HALT_INSTR, 1'b1, 1'b1, 8'd5);
    id_ready_i = 1'b0;
    repeat (2) tick();
    expect_out("halt_hold", 64'd20, HALT_INSTR, 1'b1, 1'b1, 8'd5);
    id_ready_i = 1'b1;
    push(64'd20);
    tick();
    expect_out("halt_drain", 64'd20, HALT_INSTR, 1'b0, 1'b1, 8'd5);
    tick();
    expect_out("halt_idle", 64'd20, HALT_INSTR, 1'b0, 1'b1, 8'd5);
    br_taken_i  = 1'b1;
    br_target_i = 64'h0;
    tick();
    expect_out("halt_exit", 64'd20, HALT_INSTR, 1'b0, 1'b0, 8'd0);
    br_taken_i = 1'b0;
    tick();
    expect_out("resume", 64'd0, rom_word(0), 1'b1, 1'b0, 8'd1);
    check_queue_empty("halt_sb");
    rom[5] = rom_word(5);

    // 5: ROM address wrap; redirect with decode ready consumes the live instruction.
    push(64'd0);
    br_taken_i  = 1'b1;
    br_target_i = 64'h3FC;
    tick();
    expect_out("wrap_redir", 64'd0, rom_word(0), 1'b0, 1'b0, 8'd255);
    br_taken_i = 1'b0;
    tick();
    expect_out("wrap0", 64'h3FC, rom_word(255), 1'b1, 1'b0, 8'd0);
    push(64'h3FC);
    tick();
    expect_out("wrap1", 64'h400, rom_word(0), 1'b1, 1'b0, 8'd1);

    // Back-to-back redirects: last wins.
    push(64'h400);
    br_taken_i  = 1'b1;
    br_target_i = 64'h100;
    tick();
    br_target_i = 64'h202;
    tick();
    expect_out("b2b", 64'h400, rom_word(0), 1'b0, 1'b0, 8'h80);
    br_taken_i = 1'b0;
    tick();
    expect_out("b2b_fetch", 64'h200, rom_word(128), 1'b1, 1'b0, 8'h81);
    check_queue_empty("final_sb");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
